// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract: align, add, normalise/round.
// Elastic valid/ready chain; each stage advances only when its downstream slot frees up.
module fp_addsub_pipe #(
    parameter int MANT_W = 11,
    parameter int EXP_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
    input  logic              sgn_a,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [MANT_W-1:0] mant_a,
    input  logic              sgn_b,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [MANT_W-1:0] mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sgn_r,
    output logic [EXP_W-1:0]  exp_r,
    output logic [MANT_W-1:0] mant_r,
    output logic [3:0]        flags
);

    localparam int AL_W  = MANT_W + 2;
    localparam int NRM_W = MANT_W + 3;
    localparam int SUM_W = MANT_W + 4;
    localparam int LZ_W  = $clog2(NRM_W + 1);
    localparam int EXT_W = EXP_W + 1;

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;

    assign rdy3      = ~v3 | out_ready;
    assign rdy2      = ~v2 | rdy3;
    assign rdy1      = ~v1 | rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;

    // ---------------- stage 1: swap and align ----------------
    logic              a_zero, b_zero, sb_eff, eff_sub, a_big;
    logic              x_sgn;
    logic [EXP_W-1:0]  x_exp, y_exp, d;
    logic [MANT_W-1:0] x_mant, y_mant;
    logic [AL_W-1:0]   y_ext, y_al, sh_mask;
    logic              y_sticky;

    always_comb begin
        a_zero  = (mant_a == '0);
        b_zero  = (mant_b == '0);
        sb_eff  = sgn_b ^ op;
        eff_sub = sgn_a ^ sb_eff;
        // A zero operand always lands in Y so the other one passes through unshifted.
        a_big   = ~a_zero & (b_zero | ({exp_a, mant_a} >= {exp_b, mant_b}));
        if (a_big) begin
            x_sgn  = sgn_a;
            x_exp  = exp_a;
            x_mant = mant_a;
            y_exp  = exp_b;
            y_mant = mant_b;
        end else begin
            x_sgn  = sb_eff;
            x_exp  = exp_b;
            x_mant = mant_b;
            y_exp  = exp_a;
            y_mant = mant_a;
        end
        d        = x_exp - y_exp;
        y_ext    = {y_mant, 2'b00};
        // Shifts of AL_W or more empty y_al and leave the whole of Y in sticky.
        y_al     = y_ext >> d;
        sh_mask  = ~({AL_W{1'b1}} << d);
        y_sticky = |(y_ext & sh_mask);
    end

    logic              s1_sgn, s1_sub, s1_st;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_mx;
    logic [AL_W-1:0]   s1_my;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1_sgn <= 1'b0;
            s1_sub <= 1'b0;
            s1_st  <= 1'b0;
            s1_exp <= '0;
            s1_mx  <= '0;
            s1_my  <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sgn <= x_sgn;
                s1_sub <= eff_sub;
                s1_st  <= y_sticky;
                s1_exp <= x_exp;
                s1_mx  <= x_mant;
                s1_my  <= y_al;
            end
        end
    end

    // ---------------- stage 2: add / subtract ----------------
    logic [SUM_W-1:0] x_sum, y_sum, sum_c;

    always_comb begin
        x_sum = {1'b0, s1_mx, 3'b000};
        y_sum = {1'b0, s1_my, s1_st};
        sum_c = s1_sub ? (x_sum - y_sum) : (x_sum + y_sum);
    end

    logic              s2_sgn;
    logic [EXP_W-1:0]  s2_exp;
    logic [SUM_W-1:0]  s2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            s2_sgn <= 1'b0;
            s2_exp <= '0;
            s2_sum <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                s2_sgn <= s1_sgn;
                s2_exp <= s1_exp;
                s2_sum <= sum_c;
            end
        end
    end

    // ---------------- stage 3: normalise, round, flag ----------------
    logic              carry, zero_c, unf_c, ovf_c, inx_c, inc;
    logic              g_b, r_b, s_b;
    logic [LZ_W-1:0]   lz;
    logic [NRM_W-1:0]  nrm;
    logic [EXT_W-1:0]  exp_n, exp_f;
    logic [MANT_W:0]   mant_rnd;
    logic [MANT_W-1:0] mant_f;
    logic              res_sgn;
    logic [EXP_W-1:0]  res_exp;
    logic [MANT_W-1:0] res_mant;
    logic [3:0]        res_flags;

    always_comb begin
        carry = s2_sum[SUM_W-1];
        lz    = LZ_W'(NRM_W);
        for (int i = 0; i < NRM_W; i++) begin
            if (s2_sum[i]) lz = LZ_W'(NRM_W - 1 - i);
        end
        if (carry) begin
            nrm   = {s2_sum[SUM_W-1:2], |s2_sum[1:0]};
            exp_n = EXT_W'(s2_exp) + EXT_W'(1);
        end else begin
            nrm   = s2_sum[NRM_W-1:0] << lz;
            exp_n = EXT_W'(s2_exp) - EXT_W'(lz);
        end
        zero_c = (s2_sum == '0);
        unf_c  = ~carry & ~zero_c & (EXT_W'(lz) > EXT_W'(s2_exp));
        g_b    = nrm[2];
        r_b    = nrm[1];
        s_b    = nrm[0];
        inx_c  = g_b | r_b | s_b;
        inc    = g_b & (r_b | s_b | nrm[3]);
        mant_rnd = {1'b0, nrm[NRM_W-1:3]} + (MANT_W+1)'(inc);
        if (mant_rnd[MANT_W]) begin
            mant_f = {1'b1, {(MANT_W-1){1'b0}}};
            exp_f  = exp_n + EXT_W'(1);
        end else begin
            mant_f = mant_rnd[MANT_W-1:0];
            exp_f  = exp_n;
        end
        ovf_c = (exp_f > {1'b0, {EXP_W{1'b1}}});

        res_sgn   = s2_sgn;
        res_exp   = exp_f[EXP_W-1:0];
        res_mant  = mant_f;
        res_flags = {3'b000, inx_c};
        if (zero_c) begin
            res_sgn   = 1'b0;
            res_exp   = '0;
            res_mant  = '0;
            res_flags = 4'b0010;
        end else if (unf_c) begin
            res_sgn   = 1'b0;
            res_exp   = '0;
            res_mant  = '0;
            res_flags = 4'b0111;
        end else if (ovf_c) begin
            res_exp   = '1;
            res_mant  = '1;
            res_flags = 4'b1001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3     <= 1'b0;
            sgn_r  <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            flags  <= '0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                sgn_r  <= res_sgn;
                exp_r  <= res_exp;
                mant_r <= res_mant;
                flags  <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed corner cases, random traffic with
// random backpressure, a scripted stall window and a mid-flight reset.
`timescale 1ns/1ps
module tb_fp_addsub_pipe;
    localparam int MANT_W = 11;
    localparam int EXP_W  = 5;

    typedef struct packed {
        logic              sgn;
        logic [EXP_W-1:0]  ex;
        logic [MANT_W-1:0] mt;
        logic [3:0]        fl;
    } res_t;

    typedef struct packed {
        logic              op;
        logic              sa;
        logic [EXP_W-1:0]  ea;
        logic [MANT_W-1:0] ma;
        logic              sb;
        logic [EXP_W-1:0]  eb;
        logic [MANT_W-1:0] mb;
    } stim_t;

    typedef struct {
        res_t r;
        int   acc;
        bit   chk;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              op = 1'b0;
    logic              sgn_a = 1'b0;
    logic [EXP_W-1:0]  exp_a = '0;
    logic [MANT_W-1:0] mant_a = '0;
    logic              sgn_b = 1'b0;
    logic [EXP_W-1:0]  exp_b = '0;
    logic [MANT_W-1:0] mant_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              sgn_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0] mant_r;
    logic [3:0]        flags;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    fp_addsub_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .sgn_a(sgn_a), .exp_a(exp_a), .mant_a(mant_a),
        .sgn_b(sgn_b), .exp_b(exp_b), .mant_b(mant_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sgn_r(sgn_r), .exp_r(exp_r), .mant_r(mant_r), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact value = mant * 2^exp; sum exactly, then round to nearest even.
    function automatic res_t ref_model(input stim_t s);
        longint va, vb, sum, m, q, r, half;
        int     msb, e;
        res_t   res;
        res = '0;
        va = longint'(s.ma) << s.ea;
        if (s.sa) va = -va;
        vb = longint'(s.mb) << s.eb;
        if (s.sb ^ s.op) vb = -vb;
        sum = va + vb;
        if (sum == 0) begin
            res.fl = 4'b0010;
            return res;
        end
        res.sgn = (sum < 0);
        m = (sum < 0) ? -sum : sum;
        msb = 0;
        for (int i = 0; i < 63; i++) if (m[i]) msb = i;
        e = msb - (MANT_W - 1);
        if (e < 0) begin
            res.sgn = 1'b0;
            res.fl  = 4'b0111;
            return res;
        end
        q = m >> e;
        r = m - (q << e);
        half = (e > 0) ? (longint'(1) << (e - 1)) : 0;
        if (e > 0 && (r > half || (r == half && q[0]))) q = q + 1;
        if (q == (longint'(1) << MANT_W)) begin
            q = longint'(1) << (MANT_W - 1);
            e = e + 1;
        end
        if (e > (1 << EXP_W) - 1) begin
            res.ex = '1;
            res.mt = '1;
            res.fl = 4'b1001;
        end else begin
            res.ex = EXP_W'(e);
            res.mt = MANT_W'(q);
            res.fl = {3'b000, (r != 0)};
        end
        return res;
    endfunction

    function automatic stim_t mk(input logic o, input logic sa, input int ea, input int ma,
                                 input logic sb, input int eb, input int mb);
        stim_t s;
        s.op = o;  s.sa = sa; s.ea = EXP_W'(ea); s.ma = MANT_W'(ma);
        s.sb = sb; s.eb = EXP_W'(eb); s.mb = MANT_W'(mb);
        return s;
    endfunction

    function automatic res_t rs(input logic sg, input int ex, input int mt, input logic [3:0] fl);
        res_t r;
        r.sgn = sg; r.ex = EXP_W'(ex); r.mt = MANT_W'(mt); r.fl = fl;
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    e;
        s.op = 1'($urandom_range(0, 1));
        s.sa = 1'($urandom_range(0, 1));
        s.sb = 1'($urandom_range(0, 1));
        s.ea = EXP_W'($urandom_range(0, (1 << EXP_W) - 1));
        if ($urandom_range(0, 3) == 0) begin
            s.eb = EXP_W'($urandom_range(0, (1 << EXP_W) - 1));
        end else begin
            e = int'(s.ea) + int'($urandom_range(0, 4)) - 2;
            if (e < 0) e = 0;
            if (e > (1 << EXP_W) - 1) e = (1 << EXP_W) - 1;
            s.eb = EXP_W'(e);
        end
        s.ma = {1'b1, (MANT_W-1)'($urandom)};
        s.mb = {1'b1, (MANT_W-1)'($urandom)};
        if ($urandom_range(0, 5) == 0) s.mb = s.ma ^ MANT_W'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) s.ma = '0;
        if ($urandom_range(0, 15) == 0) s.mb = '0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input stim_t s);
        op = s.op; sgn_a = s.sa; exp_a = s.ea; mant_a = s.ma;
        sgn_b = s.sb; exp_b = s.eb; mant_b = s.mb;
    endtask

    task automatic push(input res_t r, input bit chk);
        exp_t x;
        x.r = r; x.acc = cyc; x.chk = chk;
        sb_q.push_back(x);
    endtask

    // Inputs change 1ns after a rising edge; acceptance is judged at the falling edge.
    task automatic send(input stim_t s, input res_t r, input bit chk);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        drive(s);
        in_valid = 1'b1;
        while (!done) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                push(r, chk);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 200) begin
                $display("FAIL send_timeout actual=in_ready_low required=accept");
                $fatal(1, "input never accepted");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    // Output monitor: pops the scoreboard on every transfer, checks stall stability.
    initial begin
        res_t act, held;
        exp_t e;
        bit   hold_v;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            act = {sgn_r, exp_r, mant_r, flags};
            if (!rst_n) begin
                sb_q.delete();
                hold_v = 1'b0;
            end else if (out_valid) begin
                if (hold_v) begin
                    n_cmp++;
                    if (act !== held) begin
                        n_bad++;
                        $display("FAIL stall_stable actual=%h required=%h", act, held);
                    end
                end
                if (out_ready) begin
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_output actual=%h required=none", act);
                    end else begin
                        e = sb_q.pop_front();
                        if (act !== e.r) begin
                            n_bad++;
                            $display("FAIL result actual=%h required=%h", act, e.r);
                        end
                        if (e.chk) begin
                            n_cmp++;
                            if (cyc - e.acc != 3) begin
                                n_bad++;
                                $display("FAIL latency actual=%0d required=3", cyc - e.acc);
                            end
                        end
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    held   = act;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        stim_t bp_s[6];
        int    rel, issued, held_n, k;
        bit    saw_full;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'({sgn_r, exp_r, mant_r, flags}), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        send(mk(0, 0, 15, 'h400, 0, 15, 'h400), rs(0, 16, 'h400, 4'b0000), 1'b1);
        send(mk(1, 0, 15, 'h400, 0, 15, 'h400), rs(0, 0, 'h000, 4'b0010), 1'b1);
        send(mk(0, 1, 15, 'h400, 0, 15, 'h400), rs(0, 0, 'h000, 4'b0010), 1'b1);
        send(mk(0, 0, 15, 'h401, 0, 4, 'h400),  rs(0, 15, 'h402, 4'b0001), 1'b1);
        send(mk(0, 0, 15, 'h400, 0, 4, 'h400),  rs(0, 15, 'h400, 4'b0001), 1'b1);
        send(mk(0, 0, 15, 'h400, 0, 0, 'h400),  rs(0, 15, 'h400, 4'b0001), 1'b1);
        send(mk(0, 0, 31, 'h7FF, 0, 31, 'h7FF), rs(0, 31, 'h7FF, 4'b1001), 1'b1);
        send(mk(1, 0, 1, 'h400, 0, 0, 'h7FF),   rs(0, 0, 'h000, 4'b0111), 1'b1);
        send(mk(1, 0, 7, 'h000, 0, 20, 'h5A3),  rs(1, 20, 'h5A3, 4'b0000), 1'b1);
        send(mk(0, 1, 9, 'h000, 1, 3, 'h000),   rs(0, 0, 'h000, 4'b0010), 1'b1);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            s = rand_stim();
            send(s, ref_model(s), 1'b0);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_rdy = 1'b0;
        drain();

        // Scripted stall: out_ready low for relative cycles 2..8 while six ops stream in.
        for (int i = 0; i < 6; i++) bp_s[i] = rand_stim();
        rel = 0; issued = 0; saw_full = 1'b0; held_n = -1;
        while ((issued < 6 || sb_q.size() != 0) && rel < 60) begin
            out_ready = !(rel >= 2 && rel <= 8);
            in_valid  = (issued < 6);
            if (issued < 6) drive(bp_s[issued]);
            @(negedge clk);
            if (in_valid && in_ready) begin
                push(ref_model(bp_s[issued]), 1'b0);
                issued++;
            end else if (in_valid && !in_ready && !saw_full) begin
                saw_full = 1'b1;
                held_n   = sb_q.size();
            end
            @(posedge clk);
            #1;
            rel++;
        end
        in_valid = 1'b0;
        check("bp_in_ready_dropped", 32'(saw_full), 32'd1);
        check("bp_ops_held", 32'(held_n), 32'd3);
        check("bp_issued", 32'(issued), 32'd6);
        drain();

        // Reset with two operations in flight and the first one parked at the output.
        out_ready = 1'b0;
        s = rand_stim();
        send(s, ref_model(s), 1'b0);
        s = rand_stim();
        send(s, ref_model(s), 1'b0);
        k = 0;
        while (!out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rst_pre_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid_drop", 32'(out_valid), 32'd0);
        check("rst_outputs_clear", 32'({sgn_r, exp_r, mant_r, flags}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(mk(0, 0, 15, 'h400, 0, 15, 'h400), rs(0, 16, 'h400, 4'b0000), 1'b1);
        drain();
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
